// File: rtl/structure2_pkg.sv
// Shared definitions for the structure2 fully connected stages:
// FSM state encoding, data width, saturation bounds and output clamp.
package structure2_pkg;

  localparam int DATA_W  = 8;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_BIAS1,
    ST_BIAS2,
    ST_ROUND,
    ST_OUT,
    ST_DONE
  } fc_state_e;

  // Clamp a rounded value into the signed output range, optional ReLU.
  function automatic logic signed [DATA_W-1:0] sat_relu(input logic signed [31:0] v,
                                                        input logic relu);
    logic signed [DATA_W-1:0] r;
    if (relu && (v < 0))     r = '0;
    else if (v > SAT_MAX)    r = DATA_W'(SAT_MAX);
    else if (v < SAT_MIN)    r = DATA_W'(SAT_MIN);
    else                     r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/structure2_fc2_accum_if.sv
// Stream, bias-block and result signals of the fc2 accumulate stage.
interface structure2_fc2_accum_if;
  logic                                        start;
  logic                                        in_valid;
  logic signed [structure2_pkg::DATA_W-1:0]    in_act;
  logic signed [structure2_pkg::DATA_W-1:0]    in_wt;
  logic                                        in_ready;
  logic                                        bias_en;
  logic signed [structure2_pkg::DATA_W-1:0]    bias_data;
  logic                                        out_valid;
  logic signed [structure2_pkg::DATA_W-1:0]    out_data;
  logic [3:0]                                  out_idx;
  logic                                        busy;
  logic                                        done;

  modport master (
    output start, in_valid, in_act, in_wt, bias_data,
    input  in_ready, bias_en, out_valid, out_data, out_idx, busy, done
  );

  modport slave (
    input  start, in_valid, in_act, in_wt, bias_data,
    output in_ready, bias_en, out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/structure2_fc2_requant.sv
// Combinational add-bias, round-half-up, saturate and optional ReLU.
module structure2_fc2_requant
  import structure2_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 6,
  parameter int OUT_SHIFT  = 7,
  parameter int RELU       = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);

  localparam int HALF_I = 1 << (OUT_SHIFT - 1);

  logic signed [ACC_W-1:0] bias_al;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shr;
  logic signed [31:0]      wide;

  // Bias aligned to product scale, then rounded and clamped; the rounding
  // add is one bit wider so it cannot wrap on top of the accumulator wrap.
  always_comb begin
    bias_al = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< BIAS_SHIFT;
    sum     = acc + bias_al;
    rnd     = {sum[ACC_W-1], sum} + (ACC_W+1)'(HALF_I);
    shr     = rnd >>> OUT_SHIFT;
    wide    = {{(31-ACC_W){shr[ACC_W]}}, shr};
    result  = sat_relu(wide, RELU != 0);
  end

endmodule

// File: rtl/structure2_fc2_accum.sv
// fc2 multiply-accumulate: IN_LEN products per neuron, bias fetch,
// requantise and emit one signed 8-bit result per neuron.
module structure2_fc2_accum
  import structure2_pkg::*;
#(
  parameter int IN_LEN     = 64,
  parameter int OUT_NUM    = 10,
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 6,
  parameter int OUT_SHIFT  = 7,
  parameter int RELU       = 0
) (
  input logic                    clk,
  input logic                    rst,
  structure2_fc2_accum_if.slave  bus
);

  localparam int K_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

  fc_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [3:0]              n_q, n_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [3:0]              out_idx_q, out_idx_d;
  logic                    in_ready_q, in_ready_d;
  logic                    bias_en_q, bias_en_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [DATA_W-1:0] req_result;

  structure2_fc2_requant #(
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT),
    .RELU       (RELU)
  ) u_requant (
    .acc    (acc_q),
    .bias   (bias_q),
    .result (req_result)
  );

  // Next-state, datapath and registered-output decode for the layer pass.
  always_comb begin
    prod     = bus.in_act * bus.in_wt;
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};

    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    n_d        = n_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACC;
          acc_d   = '0;
          k_d     = '0;
          n_d     = '0;
        end
      end
      ST_ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_q + prod_ext;
          if (k_q == K_W'(IN_LEN - 1)) begin
            k_d     = '0;
            state_d = ST_BIAS1;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      ST_BIAS1: state_d = ST_BIAS2;
      ST_BIAS2: begin
        bias_d  = bus.bias_data;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        out_data_d = req_result;
        out_idx_d  = n_q;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (n_q == 4'(OUT_NUM - 1)) begin
          state_d = ST_DONE;
        end else begin
          n_d     = n_q + 4'd1;
          acc_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    in_ready_d  = (state_d == ST_ACC);
    bias_en_d   = (state_d == ST_BIAS1) || (state_d == ST_BIAS2);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      bias_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      n_q         <= n_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      in_ready_q  <= in_ready_d;
      bias_en_q   <= bias_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.bias_en   = bias_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
